// File: rtl/htif_tohost_mailbox.sv
// Host-target mailbox: decodes tohost/fromhost bus words, buffers console putchar
// characters in a small FIFO and turns exit commits into a one-cycle tohost strobe.
module htif_tohost_mailbox #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h8000_1000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h8000_1040,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        tohost_we,
    output logic [31:0] tohost
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EXIT_WAIT = 2'd1,
        ST_HALT      = 2'd2
    } state_t;

    function automatic logic is_putchar(input logic [31:0] hi_word);
        return (hi_word[31:24] == 8'd1) && (hi_word[23:16] == 8'd1);
    endfunction

    state_t        state_r, state_nxt_s;
    logic [31:0]   hi_r, to_lo_r, fh_lo_r, fh_hi_r, exit_code_r, tohost_r;
    logic          tohost_we_r, rvalid_r;
    logic [31:0]   rdata_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;

    logic          sel_to_lo_s, sel_to_hi_s, sel_fh_lo_s, sel_fh_hi_s;
    logic          fifo_empty_s, fifo_full_s, pop_s, push_s;
    logic [PW-1:0] fifo_count_s;
    logic          putchar_s, ready_s, accept_s, run_store_s, commit_s, exit_commit_s;
    logic          drain_done_s, pulse_s;
    logic [31:0]   exit_val_s, rd_val_s;

    assign sel_to_lo_s = (mem_addr == TOHOST_ADDR);
    assign sel_to_hi_s = (mem_addr == (TOHOST_ADDR + 32'd4));
    assign sel_fh_lo_s = (mem_addr == FROMHOST_ADDR);
    assign sel_fh_hi_s = (mem_addr == (FROMHOST_ADDR + 32'd4));

    assign fifo_count_s = wr_ptr_r - rd_ptr_r;
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s        = !fifo_empty_s && con_ready;
    assign putchar_s    = is_putchar(hi_r);

    // Bus backpressure: stall while waiting to exit, or on a putchar into a full FIFO
    always_comb begin
        ready_s = 1'b1;
        if (state_r == ST_EXIT_WAIT) begin
            ready_s = 1'b0;
        end else if ((state_r == ST_RUN) && mem_req && mem_we && sel_to_lo_s &&
                     putchar_s && fifo_full_s) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign accept_s      = mem_req && ready_s;
    assign run_store_s   = accept_s && mem_we && (state_r == ST_RUN);
    assign commit_s      = run_store_s && sel_to_lo_s;
    assign push_s        = commit_s && putchar_s;
    assign exit_commit_s = commit_s && !putchar_s;
    // Counting the pop that empties the FIFO lets the strobe follow the last pop by one cycle
    assign drain_done_s  = fifo_empty_s || ((fifo_count_s == PW'(1)) && pop_s);

    // Exit code selection: explicit exit or the catch-all unsupported code
    always_comb begin
        exit_val_s = 32'hFFFF_FFFF;
        if ((hi_r[31:24] == 8'd0) && mem_wdata[0]) begin
            exit_val_s = mem_wdata;
        end else begin
            exit_val_s = 32'hFFFF_FFFF;
        end
    end

    // Load data mux; anything outside the mailbox, or any load after halting, reads 0
    always_comb begin
        rd_val_s = 32'd0;
        if (state_r != ST_RUN) begin
            rd_val_s = 32'd0;
        end else if (sel_to_lo_s) begin
            rd_val_s = to_lo_r;
        end else if (sel_to_hi_s) begin
            rd_val_s = hi_r;
        end else if (sel_fh_lo_s) begin
            rd_val_s = fh_lo_r;
        end else if (sel_fh_hi_s) begin
            rd_val_s = fh_hi_r;
        end else begin
            rd_val_s = 32'd0;
        end
    end

    // Next-state logic and exit-strobe request
    always_comb begin
        state_nxt_s = state_r;
        pulse_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (exit_commit_s) begin
                    state_nxt_s = ST_EXIT_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EXIT_WAIT: begin
                if (drain_done_s) begin
                    state_nxt_s = ST_HALT;
                    pulse_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_EXIT_WAIT;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mailbox registers updated by accepted stores while running
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hi_r        <= 32'd0;
            to_lo_r     <= 32'd0;
            fh_lo_r     <= 32'd0;
            fh_hi_r     <= 32'd0;
            exit_code_r <= 32'd0;
        end else if (run_store_s) begin
            if (sel_to_hi_s) begin
                hi_r <= mem_wdata;
            end
            if (sel_to_lo_s) begin
                to_lo_r <= mem_wdata;
                hi_r    <= 32'd0;
                if (putchar_s) begin
                    fh_hi_r <= 32'h0101_0000;
                    fh_lo_r <= 32'd1;
                end else begin
                    exit_code_r <= exit_val_s;
                end
            end
            if (sel_fh_lo_s) begin
                fh_lo_r <= mem_wdata;
            end
            if (sel_fh_hi_s) begin
                fh_hi_r <= mem_wdata;
            end
        end
    end

    // Registered load response and exit strobe
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'd0;
            tohost_we_r <= 1'b0;
            tohost_r    <= 32'd0;
        end else begin
            rvalid_r    <= accept_s && !mem_we;
            tohost_we_r <= pulse_s;
            if (accept_s && !mem_we) begin
                rdata_r <= rd_val_s;
            end
            if (pulse_s) begin
                tohost_r <= exit_code_r;
            end
        end
    end

    // Console FIFO storage and pointers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= mem_wdata[7:0];
                wr_ptr_r                     <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    assign mem_ready  = ready_s;
    assign mem_rvalid = rvalid_r;
    assign mem_rdata  = rdata_r;
    assign con_valid  = !fifo_empty_s;
    assign con_data   = fifo_empty_s ? 8'd0 : fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign tohost_we  = tohost_we_r;
    assign tohost     = tohost_r;

endmodule

// File: doc/htif_tohost_mailbox.md
# htif_tohost_mailbox

Host-target interface mailbox between the RV64GC core's data-memory store path and the simulation testbench. It decodes 32-bit bus accesses to the `tohost`/`fromhost` words. Console-putchar commands go through a small character FIFO with a valid/ready drain port. Exit commands become a single-cycle `tohost_we`/`tohost` strobe, which the testbench turns into its PASS/FAIL report and `$finish`.

## Interface
- `TOHOST_ADDR`, default 32'h8000_1000: byte address of the tohost low word; the high word is at +4.
- `FROMHOST_ADDR`, default 32'h8000_1040: byte address of the fromhost low word; the high word is at +4.
- `FIFO_DEPTH`, default 8: console FIFO entries; must be a power of 2, ≥2.
- `CLK`  in  1: clock, rising edge.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `mem_req`  in  1: bus access request.
- `mem_we`  in  1: 1 = store, 0 = load.
- `mem_addr`  in  32: word-aligned byte address.
- `mem_wdata`  in  32: store data.
- `mem_ready`  out  1: access accepted this cycle when high with `mem_req`.
- `mem_rvalid`  out  1: load data valid.
- `mem_rdata`  out  32: load data.
- `con_valid`  out  1: console character available.
- `con_data`  out  8: console character.
- `con_ready`  in  1: console consumer accepts the character.
- `tohost_we`  out  1: exit strobe.
- `tohost`  out  32: exit code.

## Operation
- An access is accepted when `mem_req & mem_ready`. Addresses outside the four mailbox words are accepted and ignored; loads of them return 0.
- Store to `TOHOST_ADDR+4` latches `hi`.
- Store to `TOHOST_ADDR` commits `{hi, wdata}`, then clears `hi` to 0. The commit is decoded as follows:
  - `hi[31:24]==1` and `hi[23:16]==1` (putchar): push `wdata[7:0]` into the FIFO. Set fromhost to `hi=32'h0101_0000`, `lo=1`.
  - `hi[31:24]==0` and `wdata[0]==1` (exit): `exit_code=wdata`, go to EXIT_WAIT.
  - Any other value (unsupported syscall): `exit_code=32'hFFFF_FFFF`, go to EXIT_WAIT.
- Store to `FROMHOST_ADDR` or `FROMHOST_ADDR+4` writes that fromhost word. Software clears the ack by writing 0.
- Loads of `TOHOST_ADDR`/`+4` and `FROMHOST_ADDR`/`+4` return the current register value: tohost low is the last committed low word, tohost high is `hi`.
- FIFO: `con_valid = !empty`, `con_data = head`. A pop occurs on `con_valid & con_ready`. Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap modulo 2×DEPTH.
- State machine:
  - RUN → EXIT_WAIT on an exit or unsupported commit.
  - EXIT_WAIT → HALT when the FIFO is empty. This transition pulses `tohost_we` for exactly one cycle with `tohost=exit_code`.
  - HALT is terminal until reset. In HALT, stores are accepted and dropped, loads return 0, and the FIFO keeps draining.

## Timing
- Reset values: `mem_ready=1`, `mem_rvalid=0`, `mem_rdata=0`, `con_valid=0`, `con_data=0`, `tohost_we=0`, `tohost=0`.
- Reset also clears `hi`, both fromhost words and `exit_code`, empties the FIFO and sets state RUN.
- Reset mid-operation discards all queued characters and any pending exit.
- `mem_ready` is combinational. It is 0 in exactly two cases:
  - In EXIT_WAIT.
  - In RUN with `mem_req & mem_we & mem_addr==TOHOST_ADDR & putchar-decode & FIFO full`. Full is evaluated before this cycle's pop: a pop and push in the same cycle at full is not allowed.
- Load latency: 1 cycle. `mem_rvalid` is high the cycle after acceptance.
- Putchar: a commit accepted in cycle N gives `con_valid=1` in cycle N+1 if the FIFO was empty.
- The fromhost ack is visible to a load accepted in cycle N+1.
- A simultaneous push and pop at non-full depth leaves the count unchanged.
- Exit accepted in cycle N:
  - FIFO empty: state EXIT_WAIT in N+1; `tohost_we` high in N+2, `tohost=exit_code` valid in N+2.
  - FIFO not empty: `tohost_we` rises 1 cycle after the cycle in which the last character pops.
- `tohost` holds `exit_code` after the pulse.

## Test plan
- Reset, then exit: store `TOHOST_ADDR+4`=0, then `TOHOST_ADDR`=32'h1 → exactly one `tohost_we` pulse 2 cycles later, `tohost`=32'h0000_0001; no further pulses in HALT.
- Failing test: store `TOHOST_ADDR`=32'h7 (test 3) → `tohost`=32'h0000_0007 with a single strobe.
- Console with backpressure:
  - Stimulus: putchar 'H','i' (`hi`=32'h0101_0000 each time) with `con_ready`=0 for 20 cycles, then 1.
  - Required: `con_data` sequence 8'h48, 8'h69; fromhost low reads 1 and high reads 32'h0101_0000; writing 0 to `FROMHOST_ADDR` clears the low word.
- FIFO full: 9 putchars with `con_ready`=0 and DEPTH=8 → `mem_ready`=0 on the 9th; raising `con_ready` lets it proceed; 9 characters are delivered in order.
- Drain before exit: 3 putchars queued with `con_ready`=0, then exit=32'h1, then `con_ready`=1 → `mem_ready`=0 in EXIT_WAIT; `tohost_we` pulses only after the 3rd pop.
- Unsupported command: `hi`=0, lo=32'h8000_2000 → `tohost`=32'hFFFF_FFFF strobe. Assert RSTn low mid-drain → all outputs return to reset values and the FIFO is empty.
